// File: rtl/gate_check_pkg.sv
// Shared definitions for the gate vector checker: gate_sel encodings,
// FSM state encoding and the per-gate truth-table size.
package gate_check_pkg;

    localparam logic [2:0] GATE_AOI  = 3'd0;
    localparam logic [2:0] GATE_NOT  = 3'd1;
    localparam logic [2:0] GATE_NAND = 3'd2;
    localparam logic [2:0] GATE_AND  = 3'd3;
    localparam logic [2:0] GATE_NOR  = 3'd4;
    localparam logic [2:0] GATE_OR   = 3'd5;
    localparam logic [2:0] GATE_XNOR = 3'd6;
    localparam logic [2:0] GATE_XOR  = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    // Exhaustive vector count: aoi uses a,b,c; not uses a; the rest use a,b.
    function automatic logic [3:0] vec_count(input logic [2:0] sel);
        case (sel)
            GATE_AOI: return 4'd8;
            GATE_NOT: return 4'd2;
            default:  return 4'd4;
        endcase
    endfunction

endpackage

// File: rtl/golden_gate_model.sv
// Combinational reference for each gate type; vec bit0=a, bit1=b, bit2=c.
module golden_gate_model
    import gate_check_pkg::*;
(
    input  logic [2:0] gate_sel,
    input  logic [2:0] vec,
    output logic       expected
);

    logic a, b, c;
    assign a = vec[0];
    assign b = vec[1];
    assign c = vec[2];

    // Select the expected output for the gate being checked.
    always_comb begin
        expected = 1'b0;
        case (gate_sel)
            GATE_AOI:  expected = ~((a & b) | c);
            GATE_NOT:  expected = ~a;
            GATE_NAND: expected = ~(a & b);
            GATE_AND:  expected = a & b;
            GATE_NOR:  expected = ~(a | b);
            GATE_OR:   expected = a | b;
            GATE_XNOR: expected = ~(a ^ b);
            GATE_XOR:  expected = a ^ b;
            default:   expected = 1'b0;
        endcase
    end

endmodule

// File: rtl/gate_vector_checker.sv
// Drives exhaustive truth-table vectors into one gate-under-test, waits
// SETTLE_CYCLES, samples its output and tallies pass/fail against the
// golden model.
// Optional macro FIRST_FAIL_CAPTURE_EN adds fail_seen/fail_vec/fail_got,
// which record the first failing vector of a run.
module gate_vector_checker
    import gate_check_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] gate_sel,
    output logic [2:0] dut_in,
    input  logic       dut_out,
    output logic       busy,
    output logic       done,
    output logic [3:0] pass_cnt,
    output logic [3:0] fail_cnt,
    output logic       all_pass
`ifdef FIRST_FAIL_CAPTURE_EN
    ,
    output logic       fail_seen,
    output logic [2:0] fail_vec,
    output logic       fail_got
`endif
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_e     state;
    logic [2:0] sel_q;
    logic [2:0] vec;
    logic [3:0] settle_cnt;
    logic       dut_out_q;
    logic       expected;
    logic       hit;
    logic       last_vec;

    golden_gate_model u_golden (
        .gate_sel (sel_q),
        .vec      (vec),
        .expected (expected)
    );

    assign hit      = (dut_out_q == expected);
    assign last_vec = ({1'b0, vec} == (vec_count(sel_q) - 4'd1));

    // Register the gate output while settling; the last SETTLE cycle's
    // sample is what CHECK compares.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            dut_out_q <= 1'b0;
        else if (state == ST_SETTLE)
            dut_out_q <= dut_out;
    end

    // Run sequencer: drive, settle, check, repeat until the table is done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            sel_q      <= 3'd0;
            vec        <= 3'd0;
            settle_cnt <= 4'd0;
            dut_in     <= 3'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass_cnt   <= 4'd0;
            fail_cnt   <= 4'd0;
            all_pass   <= 1'b0;
`ifdef FIRST_FAIL_CAPTURE_EN
            fail_seen  <= 1'b0;
            fail_vec   <= 3'd0;
            fail_got   <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        sel_q     <= gate_sel;
                        vec       <= 3'd0;
                        pass_cnt  <= 4'd0;
                        fail_cnt  <= 4'd0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        all_pass  <= 1'b0;
`ifdef FIRST_FAIL_CAPTURE_EN
                        fail_seen <= 1'b0;
                        fail_vec  <= 3'd0;
                        fail_got  <= 1'b0;
`endif
                        state     <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    // Unused inputs stay 0 because vec never exceeds the
                    // gate's own input range.
                    dut_in     <= vec;
                    settle_cnt <= SETTLE_LOAD;
                    state      <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (settle_cnt == 4'd0)
                        state <= ST_CHECK;
                    else
                        settle_cnt <= settle_cnt - 4'd1;
                end
                ST_CHECK: begin
                    if (hit) begin
                        pass_cnt <= pass_cnt + 4'd1;
                    end else begin
                        fail_cnt <= fail_cnt + 4'd1;
`ifdef FIRST_FAIL_CAPTURE_EN
                        if (!fail_seen) begin
                            fail_seen <= 1'b1;
                            fail_vec  <= vec;
                            fail_got  <= dut_out_q;
                        end
`endif
                    end
                    if (last_vec) begin
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        all_pass <= hit && (fail_cnt == 4'd0);
                        state    <= ST_DONE;
                    end else begin
                        vec   <= vec + 3'd1;
                        state <= ST_DRIVE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_vector_checker.sv
// Directed bench for gate_vector_checker: attaches a behavioural gate
// (correct or deliberately wrong) to dut_in/dut_out and checks counts,
// timing, reset and start-ignore behaviour against hand-computed values.
module tb_gate_vector_checker;

    logic       clk;
    logic       rst;
    logic       start;
    logic [2:0] gate_sel;
    logic [2:0] dut_in;
    logic       dut_out;
    logic       busy;
    logic       done;
    logic [3:0] pass_cnt;
    logic [3:0] fail_cnt;
    logic       all_pass;
`ifdef FIRST_FAIL_CAPTURE_EN
    logic       fail_seen;
    logic [2:0] fail_vec;
    logic       fail_got;
`endif

    int checks = 0;
    int errors = 0;
    int kind;      // attached gate: 0..7 as gate_sel, 8 = buffer on a
    int ncyc;
    logic bit2_seen;

    gate_vector_checker #(.SETTLE_CYCLES(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .gate_sel (gate_sel),
        .dut_in   (dut_in),
        .dut_out  (dut_out),
        .busy     (busy),
        .done     (done),
        .pass_cnt (pass_cnt),
        .fail_cnt (fail_cnt),
        .all_pass (all_pass)
`ifdef FIRST_FAIL_CAPTURE_EN
        ,
        .fail_seen(fail_seen),
        .fail_vec (fail_vec),
        .fail_got (fail_got)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural gate instance sitting between dut_in and dut_out.
    always_comb begin
        case (kind)
            0: dut_out = ~((dut_in[0] & dut_in[1]) | dut_in[2]);
            1: dut_out = ~dut_in[0];
            2: dut_out = ~(dut_in[0] & dut_in[1]);
            3: dut_out = dut_in[0] & dut_in[1];
            4: dut_out = ~(dut_in[0] | dut_in[1]);
            5: dut_out = dut_in[0] | dut_in[1];
            6: dut_out = ~(dut_in[0] ^ dut_in[1]);
            7: dut_out = dut_in[0] ^ dut_in[1];
            8: dut_out = dut_in[0];
            default: dut_out = 1'b0;
        endcase
    end

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic pulse_start(input logic [2:0] sel);
        gate_sel = sel;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
    endtask

    // Cycles after the start edge until done is seen; -1 on timeout.
    task automatic wait_done(output int n);
        n = -1;
        for (int i = 1; i <= 400; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; gate_sel = 3'd0; kind = 0;
        #1;
        chk("rst_dut_in",   8'(dut_in),   0);
        chk("rst_busy",     8'(busy),     0);
        chk("rst_done",     8'(done),     0);
        chk("rst_pass",     8'(pass_cnt), 0);
        chk("rst_fail",     8'(fail_cnt), 0);
        chk("rst_all_pass", 8'(all_pass), 0);
`ifdef FIRST_FAIL_CAPTURE_EN
        chk("rst_fail_seen", 8'(fail_seen), 0);
`endif
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // Correct aoi: 8 vectors * 4 cycles.
        kind = 0;
        pulse_start(3'd0);
        chk("aoi_busy_after_start", 8'(busy), 1);
        wait_done(ncyc);
        chk("aoi_latency",  8'(ncyc),     32);
        chk("aoi_pass",     8'(pass_cnt), 8);
        chk("aoi_fail",     8'(fail_cnt), 0);
        chk("aoi_all_pass", 8'(all_pass), 1);
        chk("aoi_busy_end", 8'(busy),     0);

        // not-gate select with a buffer attached: both vectors fail.
        kind = 8;
        pulse_start(3'd1);
        wait_done(ncyc);
        chk("not_latency",  8'(ncyc),     8);
        chk("not_pass",     8'(pass_cnt), 0);
        chk("not_fail",     8'(fail_cnt), 2);
        chk("not_all_pass", 8'(all_pass), 0);
`ifdef FIRST_FAIL_CAPTURE_EN
        chk("not_fail_seen", 8'(fail_seen), 1);
        chk("not_fail_vec",  8'(fail_vec),  0);
        chk("not_fail_got",  8'(fail_got),  0);
`endif

        // xor select with xnor attached; watch the stimulus sequence.
        kind = 6;
        bit2_seen = 1'b0;
        pulse_start(3'd7);
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk); #1;
            bit2_seen |= dut_in[2];
            if ((c - 1) % 4 == 0)
                chk($sformatf("xor_dut_in_v%0d", (c - 1) / 4), 8'(dut_in), 8'((c - 1) / 4));
        end
        chk("xor_done_at_16", 8'(done),      1);
        chk("xor_dut_in_c",   8'(bit2_seen), 0);
        chk("xor_fail",       8'(fail_cnt),  4);
        chk("xor_pass",       8'(pass_cnt),  0);
`ifdef FIRST_FAIL_CAPTURE_EN
        chk("xor_fail_vec",   8'(fail_vec),  0);
        chk("xor_fail_got",   8'(fail_got),  1);
`endif

        // Reset during SETTLE of vector 2 on nand.
        kind = 2;
        pulse_start(3'd2);
        repeat (9) @(posedge clk);
        #1;
        chk("nand_partial_pass", 8'(pass_cnt), 2);
        chk("nand_busy_mid",     8'(busy),     1);
        #2 rst = 1'b1;
        #1;
        chk("abort_dut_in",   8'(dut_in),   0);
        chk("abort_busy",     8'(busy),     0);
        chk("abort_done",     8'(done),     0);
        chk("abort_pass",     8'(pass_cnt), 0);
        chk("abort_fail",     8'(fail_cnt), 0);
        chk("abort_all_pass", 8'(all_pass), 0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        pulse_start(3'd2);
        wait_done(ncyc);
        chk("nand_latency",  8'(ncyc),     16);
        chk("nand_pass",     8'(pass_cnt), 4);
        chk("nand_fail",     8'(fail_cnt), 0);
        chk("nand_all_pass", 8'(all_pass), 1);

        // start pulse and gate_sel change mid-run are ignored.
        kind = 0;
        pulse_start(3'd0);
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1; gate_sel = 3'd1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(ncyc);
        chk("ignore_latency", 8'(ncyc),     29);
        chk("ignore_pass",    8'(pass_cnt), 8);
        chk("ignore_fail",    8'(fail_cnt), 0);

        // Restart from DONE with or.
        kind = 5;
        pulse_start(3'd5);
        chk("restart_pass_clr", 8'(pass_cnt), 0);
        chk("restart_done_clr", 8'(done),     0);
        chk("restart_busy",     8'(busy),     1);
        wait_done(ncyc);
        chk("or_latency",  8'(ncyc),     16);
        chk("or_pass",     8'(pass_cnt), 4);
        chk("or_fail",     8'(fail_cnt), 0);
        chk("or_all_pass", 8'(all_pass), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
